adder_64_result_serializer: RTL

//   Downstream stage of adder_64. Captures each {carry_out, sum_out} result flagged by

---
 rtl/adder_64_result_serializer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/adder_64_result_serializer.sv
// adder_64_result_serializer
// Queues {carry, sum} results from adder_64 in a small FIFO and streams each one
// out LSB-first as DATA_W/BEAT_W narrow beats over a valid/ready handshake.
// adder_64 cannot be stalled, so a result arriving at a full FIFO is dropped and
// remembered in a sticky overflow flag.

module adder_64_result_serializer #(
  parameter int DATA_W     = 64,
  parameter int BEAT_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             sum_in,
  input  logic                          carry_in,
  input  logic                          din_en,
  output logic [BEAT_W-1:0]             dout_word,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          dout_carry,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int BEATS   = DATA_W / BEAT_W;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CW      = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Result FIFO: entry = {carry, sum}
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CW-1:0]      count_q;
  logic               overflow_q;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               drop;

  // Serializer state
  state_t             state_q;
  state_t             state_d;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  shift_d;
  logic [CNT_W-1:0]   beat_q;
  logic [CNT_W-1:0]   beat_d;
  logic [CNT_W-1:0]   beat_inc;
  logic               carry_q;
  logic               carry_d;
  logic               last_q;
  logic               last_d;
  logic               handshake;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign handshake  = (state_q == SEND) && dout_ready;
  assign beat_inc   = beat_q + CNT_W'(1);

  // A full FIFO still takes a new result when the head leaves on the same edge.
  assign push = din_en && (!fifo_full || pop);
  assign drop = din_en && !push;

  // Next-state and beat datapath: load from FIFO head, shift, or hold.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    carry_d = carry_q;
    last_d  = last_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head[DATA_W-1:0];
          carry_d = head[DATA_W];
          beat_d  = '0;
          last_d  = (BEATS == 1);
          state_d = SEND;
        end
      end

      SEND: begin
        if (handshake) begin
          if (!last_q) begin
            shift_d = shift_q >> BEAT_W;
            beat_d  = beat_inc;
            last_d  = (beat_inc == CNT_W'(BEATS - 1));
          end else if (!fifo_empty) begin
            // Reload on the final handshake so consecutive results have no bubble.
            pop     = 1'b1;
            shift_d = head[DATA_W-1:0];
            carry_d = head[DATA_W];
            beat_d  = '0;
            last_d  = (BEATS == 1);
          end else begin
            shift_d = '0;
            carry_d = 1'b0;
            beat_d  = '0;
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Beat datapath registers; these drive the outputs directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      beat_q  <= '0;
      carry_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      beat_q  <= beat_d;
      carry_q <= carry_d;
      last_q  <= last_d;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the pointers and count define which
    // entries are meaningful, and stale contents are never read.
    if (rst_n && push) begin
      mem[wr_ptr] <= {carry_in, sum_in};
    end
  end

  // Outputs come straight from registers; dout_ready has no combinational path here.
  assign dout_valid = (state_q == SEND);
  assign dout_word  = shift_q[BEAT_W-1:0];
  assign dout_last  = last_q;
  assign dout_carry = last_q & carry_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
